lfsr64_stream_ctrl: RTL and testbench

Sequencer for the 64-bit XNOR LFSR register, `lfsr64`, which takes `first` (load seed and step) and `set` (step) inputs. It accepts a seed and word count and drives the LFSR load and step controls. It then runs a configurable warm-up and delivers the requested number of keystream words on a valid/ready stream. Abort and lock-up-seed rejection are included.

---
 rtl/lfsr64_stream_ctrl.sv | 122 ++++++++++++
 tb/tb_lfsr64_stream_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr64_stream_ctrl.sv
// Stream sequencer for a 64-bit XNOR LFSR: load, warm-up, then
// deliver a counted run of keystream words over valid/ready.
module lfsr64_stream_ctrl #(
  parameter int WARMUP = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      seed_in,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  output logic [63:0]      lfsr_seed,
  output logic             lfsr_first,
  output logic             lfsr_set,
  input  logic [63:0]      lfsr_q,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic [CNT_W-1:0] words_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_RUN,
    S_FIN
  } state_t;

  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_t           r_state;
  logic [WC_W-1:0]  r_wcnt;
  logic [63:0]      r_seed;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_sent;
  logic             r_serr;

  logic             w_hs;
  logic [CNT_W-1:0] w_sent_nx;

  assign w_hs      = out_valid & out_ready;
  assign w_sent_nx = r_sent + CNT_W'(1);

  // Strobes are gated by abort in the same cycle so nothing moves.
  assign lfsr_first = (r_state == S_LOAD) && !abort;
  assign lfsr_set   = !abort &&
                      ((r_state == S_WARM) ||
                       ((r_state == S_RUN) && out_ready));
  assign out_valid  = (r_state == S_RUN) && !abort;

  assign out_data   = lfsr_q;
  assign lfsr_seed  = r_seed;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);
  assign seed_err   = r_serr;
  assign words_sent = r_sent;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_seed  <= '0;
      r_num   <= '0;
      r_sent  <= '0;
      r_serr  <= 1'b0;
    end else begin
      r_serr <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            // abort wins over a coincident start
            if (start && !abort) begin
              if (&seed_in) begin
                r_serr <= 1'b1;
              end else begin
                r_seed  <= seed_in;
                r_num   <= num_words;
                r_sent  <= '0;
                r_state <= (num_words == '0) ? S_FIN : S_LOAD;
              end
            end
          end
          S_LOAD: begin
            r_wcnt  <= '0;
            r_state <= (WARMUP > 0) ? S_WARM : S_RUN;
          end
          S_WARM: begin
            if (r_wcnt == WC_LAST) begin
              r_state <= S_RUN;
            end else begin
              r_wcnt <= r_wcnt + WC_W'(1);
            end
          end
          S_RUN: begin
            if (w_hs) begin
              r_sent <= w_sent_nx;
              if (w_sent_nx == r_num) begin
                r_state <= S_FIN;
              end
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr64_stream_ctrl.sv
// Bench: two controllers (WARMUP 0 and 2) on shared stimulus, each
// driving its own LFSR model; words are scoreboarded per instance.
module tb_lfsr64_stream_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [63:0]   seed_in;
  logic [CW-1:0] num;
  logic          abort;
  logic          rdy;

  logic [63:0]   sd0, q0m, d0;
  logic          f0, s0, v0, b0, dn0, se0;
  logic [CW-1:0] ws0;
  logic [63:0]   sd2, q2m, d2;
  logic          f2, s2, v2, b2, dn2, se2;
  logic [CW-1:0] ws2;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [63:0] q0[$];
  logic [63:0] q2[$];

  always #5 clk = ~clk;

  lfsr64_stream_ctrl #(.WARMUP(0), .CNT_W(CW)) u0 (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
    .num_words(num), .abort(abort), .lfsr_seed(sd0),
    .lfsr_first(f0), .lfsr_set(s0), .lfsr_q(q0m),
    .out_data(d0), .out_valid(v0), .out_ready(rdy),
    .busy(b0), .done(dn0), .seed_err(se0), .words_sent(ws0)
  );

  lfsr64_stream_ctrl #(.WARMUP(2), .CNT_W(CW)) u2 (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
    .num_words(num), .abort(abort), .lfsr_seed(sd2),
    .lfsr_first(f2), .lfsr_set(s2), .lfsr_q(q2m),
    .out_data(d2), .out_valid(v2), .out_ready(rdy),
    .busy(b2), .done(dn2), .seed_err(se2), .words_sent(ws2)
  );

  function automatic logic [63:0] stp(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  // Golden LFSR registers
  initial begin
    q0m = '0;
    q2m = '0;
  end
  always @(posedge clk) begin
    if (f0) q0m <= stp(sd0);
    else if (s0) q0m <= stp(q0m);
    if (f2) q2m <= stp(sd2);
    else if (s2) q2m <= stp(q2m);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every handshake
  always @(negedge clk) begin
    logic [63:0] e;
    if (v0 && rdy) begin
      e = 'x;
      if (q0.size() > 0) e = q0.pop_front();
      chk("sb_w0", d0, e);
    end
    if (v2 && rdy) begin
      e = 'x;
      if (q2.size() > 0) e = q2.pop_front();
      chk("sb_w2", d2, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic go(input logic [63:0] s, input logic [CW-1:0] n);
    logic [63:0] w;
    start   = 1'b1;
    seed_in = s;
    num     = n;
    if (!(&s) && n != '0) begin
      w = s;
      for (int i = 0; i < int'(n); i++) begin
        w = stp(w);
        q0.push_back(w);
      end
      w = stp(stp(s));
      for (int i = 0; i < int'(n); i++) begin
        w = stp(w);
        q2.push_back(w);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (b0 || b2); i++) begin
      tick();
      smp();
    end
    chk("idle_timeout", {62'd0, b0, b2}, 64'd0);
  endtask

  initial begin
    logic [63:0] sa;
    sa      = 64'h1234_5678_9ABC_DEF0;
    reset   = 1'b1;
    start   = 1'b0;
    seed_in = '0;
    num     = '0;
    abort   = 1'b0;
    rdy     = 1'b1;

    // reset state
    tick(); tick(); smp();
    chk("rst_busy", {62'd0, b0, b2}, 64'd0);
    chk("rst_strb", {60'd0, f0, s0, f2, s2}, 64'd0);
    chk("rst_valid", {62'd0, v0, v2}, 64'd0);
    chk("rst_flags", {60'd0, dn0, se0, dn2, se2}, 64'd0);
    chk("rst_ws", {32'd0, ws0, ws2}, 64'd0);
    chk("rst_seed", sd0 | sd2, 64'd0);
    tick(); reset = 1'b0; smp();

    // seed 0, 3 words, WARMUP 0
    tick(); go(64'd0, 3); smp();
    chk("r1_c0_busy", {63'd0, b0}, 64'd0);
    tick(); start = 1'b0; smp();
    chk("r1_c1_first0", {63'd0, f0}, 64'd1);
    chk("r1_c1_first2", {63'd0, f2}, 64'd1);
    chk("r1_c1_set0", {63'd0, s0}, 64'd0);
    tick(); smp();
    chk("r1_c2_valid", {63'd0, v0}, 64'd1);
    chk("r1_c2_data", d0, 64'h1);
    tick(); smp();
    chk("r1_c3_data", d0, 64'h3);
    tick(); smp();
    chk("r1_c4_data", d0, 64'h7);
    tick(); smp();
    chk("r1_c5_done", {63'd0, dn0}, 64'd1);
    chk("r1_c5_ws", {48'd0, ws0}, 64'd3);
    chk("r1_c5_valid", {63'd0, v0}, 64'd0);
    wait_idle();

    // seed 0, 1 word, WARMUP 2 instance
    tick(); go(64'd0, 1); smp();
    tick(); start = 1'b0; smp();
    chk("r2_c1_first", {63'd0, f2}, 64'd1);
    tick(); smp();
    chk("r2_c2_strb", {61'd0, f2, s2, v2}, 64'b010);
    tick(); smp();
    chk("r2_c3_strb", {61'd0, f2, s2, v2}, 64'b010);
    tick(); smp();
    chk("r2_c4_valid", {63'd0, v2}, 64'd1);
    chk("r2_c4_data", d2, 64'h7);
    tick(); smp();
    chk("r2_c5_done", {63'd0, dn2}, 64'd1);
    chk("r2_c5_ws", {48'd0, ws2}, 64'd1);
    wait_idle();

    // back-pressure on the WARMUP 0 instance
    tick(); go(sa, 2); smp();
    tick(); start = 1'b0; smp();
    tick(); smp();
    chk("r3_c2_data", d0, stp(sa));
    tick(); rdy = 1'b0; smp();
    chk("r3_c3_data", d0, stp(stp(sa)));
    chk("r3_c3_set", {62'd0, s0, v0}, 64'b01);
    tick(); smp();
    chk("r3_c4_data", d0, stp(stp(sa)));
    chk("r3_c4_set", {62'd0, s0, v0}, 64'b01);
    tick(); rdy = 1'b1; smp();
    chk("r3_c5_data", d0, stp(stp(sa)));
    tick(); smp();
    chk("r3_c6_done", {63'd0, dn0}, 64'd1);
    chk("r3_c6_ws", {48'd0, ws0}, 64'd2);
    wait_idle();

    // lock-up seed rejected
    tick(); go('1, 5); smp();
    tick(); start = 1'b0; smp();
    chk("r4_serr", {62'd0, se0, se2}, 64'b11);
    chk("r4_quiet", {60'd0, b0, f0, b2, f2}, 64'd0);
    chk("r4_seed_kept", sd0, sa);
    tick(); smp();
    chk("r4_serr_pulse", {62'd0, se0, b0}, 64'd0);

    // zero-length run
    tick(); go(64'h55, 0); smp();
    tick(); start = 1'b0; smp();
    chk("r5_done", {62'd0, dn0, b0}, 64'b11);
    chk("r5_strb", {60'd0, f0, s0, f2, s2}, 64'd0);
    chk("r5_ws", {48'd0, ws0}, 64'd0);
    tick(); smp();
    chk("r5_after", {62'd0, dn0, b0}, 64'd0);

    // abort in WARMUP (and first RUN cycle of instance 0)
    tick(); go(64'hA5, 4); smp();
    tick(); start = 1'b0; smp();
    tick(); abort = 1'b1; smp();
    chk("r6_gated", {61'd0, s2, v0, s0}, 64'd0);
    tick(); abort = 1'b0; smp();
    chk("r6_idle", {60'd0, b0, b2, dn0, dn2}, 64'd0);
    chk("r6_ws", {32'd0, ws0, ws2}, 64'd0);
    q0.delete(); q2.delete();

    // abort in RUN with out_ready high
    tick(); go(64'hA5, 4); smp();
    tick(); start = 1'b0; smp();
    tick(); smp();
    tick(); abort = 1'b1; smp();
    chk("r7_gated", {62'd0, v0, s0}, 64'd0);
    tick(); abort = 1'b0; smp();
    chk("r7_ws", {48'd0, ws0}, 64'd1);
    chk("r7_idle", {62'd0, b0, dn0}, 64'd0);
    q0.delete(); q2.delete();

    // normal run after abort
    tick(); go(64'h0F, 2); smp();
    tick(); start = 1'b0; smp();
    tick(); smp();
    tick(); smp();
    tick(); smp();
    chk("r8_done", {63'd0, dn0}, 64'd1);
    chk("r8_ws", {48'd0, ws0}, 64'd2);
    wait_idle();

    // reset in the middle of RUN
    tick(); go(64'h99, 10); smp();
    tick(); start = 1'b0; smp();
    tick(); smp();
    tick(); reset = 1'b1; smp();
    tick(); reset = 1'b0; smp();
    chk("r9_rst_ctl", {59'd0, b0, v0, f0, s0, dn0}, 64'd0);
    chk("r9_rst_ws", {48'd0, ws0}, 64'd0);
    chk("r9_rst_seed", sd0, 64'd0);
    chk("r9_rst_b2", {63'd0, b2}, 64'd0);
    q0.delete(); q2.delete();
    tick(); go(64'd0, 1); smp();
    tick(); start = 1'b0; smp();
    tick(); smp();
    chk("r9_first_word", d0, 64'h1);
    chk("r9_valid", {63'd0, v0}, 64'd1);
    wait_idle();

    chk("sb_drained", 64'(q0.size() + q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
